// File: rtl/seg_display_mux.sv
// Multiplexed 7-segment driver: serial binary-to-BCD converter, held display register and windowed scan.
// Latency: a load commits to the display VALUE_W+1 clocks later; seg/an/dp are registered one clock after the scan index.
// Backpressure: busy is high while converting; a load seen while busy is parked in a one-deep latest-wins slot. Optional cursor blink under SEG_BLINK_EN.
module seg_display_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 20,
    parameter int BCD_DIGITS  = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 250,
    localparam int WIN_W      = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1,
    localparam int CUR_W      = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    input  logic [WIN_W-1:0]      window_lsd,
    input  logic [NUM_DIGITS-1:0] dp_pos,
    input  logic                  blank_lz,
    input  logic                  cursor_en,
    input  logic [CUR_W-1:0]      cursor,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  dp
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = ((WIN_W > CUR_W) ? WIN_W : CUR_W) + 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

    state_t             state_q, state_d;
    logic               load_q;
    logic               load_pulse;
    logic               start_conv;
    logic               use_pend;
    logic               do_commit;
    logic [VALUE_W-1:0] start_val;
    logic [VALUE_W-1:0] sh_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic               ovf_acc_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic               pend_vld_q;
    logic [VALUE_W-1:0] pend_dat_q;
    logic [BCD_W-1:0]   disp_bcd_q;
    logic               ovf_q;

    // A held load level counts once, so only its rising edge is a request.
    assign load_pulse = load & ~load_q;
    assign busy       = (state_q != S_IDLE);
    assign overflow   = ovf_q;
    assign start_val  = use_pend ? pend_dat_q : value;

    // Converter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load;
        end
    end

    // Converter next state; a load arriving during COMMIT is newer than the parked one.
    always_comb begin
        state_d    = state_q;
        start_conv = 1'b0;
        use_pend   = 1'b0;
        do_commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_pulse) begin
                    state_d    = S_CONV;
                    start_conv = 1'b1;
                end
            end
            S_CONV: begin
                if (bit_cnt_q == CNT_W'(VALUE_W - 1)) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                do_commit = 1'b1;
                if (load_pulse || pend_vld_q) begin
                    state_d    = S_CONV;
                    start_conv = 1'b1;
                    use_pend   = ~load_pulse;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
    end

    // Shift datapath, pending slot and display register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q       <= '0;
            bcd_q      <= '0;
            ovf_acc_q  <= 1'b0;
            bit_cnt_q  <= '0;
            pend_vld_q <= 1'b0;
            pend_dat_q <= '0;
            disp_bcd_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (start_conv) begin
                sh_q      <= start_val;
                bcd_q     <= '0;
                ovf_acc_q <= 1'b0;
                bit_cnt_q <= '0;
            end else if (state_q == S_CONV) begin
                bcd_q     <= {bcd_adj[BCD_W-2:0], sh_q[VALUE_W-1]};
                ovf_acc_q <= ovf_acc_q | bcd_adj[BCD_W-1];
                sh_q      <= sh_q << 1;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (load_pulse && (state_q == S_CONV)) begin
                pend_vld_q <= 1'b1;
                pend_dat_q <= value;
            end else if (start_conv) begin
                pend_vld_q <= 1'b0;
            end
            if (do_commit) begin
                disp_bcd_q <= bcd_q;
                ovf_q      <= ovf_acc_q;
            end
        end
    end

    logic [REF_W-1:0] ref_cnt_q;
    logic [CUR_W-1:0] scan_p_q;
    logic             scan_tick;

    assign scan_tick = (ref_cnt_q == REF_W'(REFRESH_DIV - 1));

    // Refresh prescaler and scan position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
            scan_p_q  <= '0;
        end else if (scan_tick) begin
            ref_cnt_q <= '0;
            scan_p_q  <= (scan_p_q == CUR_W'(NUM_DIGITS - 1)) ? '0 : scan_p_q + CUR_W'(1);
        end else begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
    end

    logic cursor_hit;

`ifdef SEG_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_ph_q;

    // Blink phase flips after every BLINK_DIV scan steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (scan_tick) begin
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BLK_W'(1);
            end
        end
    end

    assign cursor_hit = cursor_en & blink_ph_q & (scan_p_q == cursor);
`else
    logic unused_cursor;
    assign unused_cursor = ^{cursor_en, cursor};
    assign cursor_hit    = 1'b0;
`endif

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    logic [IDX_W-1:0]      idx;
    logic [3:0]            digit;
    logic                  in_range;
    logic                  upper_zero;
    logic                  dp_above;
    logic                  lz_blank;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic [NUM_DIGITS-1:0] an_d;

    // Pick the windowed digit and decide overflow / blanking / cursor in priority order.
    always_comb begin
        idx        = IDX_W'(window_lsd) + IDX_W'(scan_p_q);
        in_range   = (idx < IDX_W'(BCD_DIGITS));
        digit      = 4'd0;
        upper_zero = 1'b1;
        dp_above   = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (IDX_W'(i) == idx) digit = disp_bcd_q[i*4 +: 4];
            if ((IDX_W'(i) >= idx) && (disp_bcd_q[i*4 +: 4] != 4'd0)) upper_zero = 1'b0;
        end
        // A lit DP at or left of this position keeps the zero visible.
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((CUR_W'(j) >= scan_p_q) && dp_pos[j]) dp_above = 1'b1;
        end
        lz_blank = blank_lz & upper_zero & (scan_p_q != '0) & ~dp_above;
        if (ovf_q)                     seg_d = SEG_DASH;
        else if (!in_range || lz_blank) seg_d = SEG_BLANK;
        else if (cursor_hit)           seg_d = SEG_BLANK;
        else                           seg_d = seg_decode(digit);
        dp_d = ovf_q ? 1'b1 : ~dp_pos[scan_p_q];
        an_d = ~(NUM_DIGITS'(1) << scan_p_q);
    end

    // Registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
            dp  <= dp_d;
        end
    end

endmodule
